nv_nvdla_cacc_mac_rcv: RTL and testbench
========================================

# nv_nvdla_cacc_mac_rcv

Receiving end of the mac2accu interface, placed at the accumulator input of CACC. It absorbs every MAC result beat without back-pressure and accumulates partial sums per stripe atom across channel-group passes. On the final pass it emits completed sums through a valid/ready output FIFO to the CACC delivery path. Overflow of either storage element is flagged, never stalled.

## Interface
Parameters:
- ATOMK_HALF, 8, result lanes per beat
- RESULT_WIDTH, 19, signed width of one mac2accu lane
- ACC_WIDTH, 34, signed accumulator width (> RESULT_WIDTH)
- DEPTH, 8, accumulation entries (atoms per stripe)
- OUT_DEPTH, 4, output FIFO entries

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  async active-low reset
- mac2accu_pvld  in  1  beat valid; no ready exists
- mac2accu_mask  in  ATOMK_HALF  lane valid
- mac2accu_mode  in  1  conv mode
- mac2accu_data  in  ATOMK_HALF*RESULT_WIDTH  lane i at [i*RW +: RW]
- mac2accu_pd  in  9  [0] stripe_st, [1] stripe_end, [2] channel_end (last pass, held on all beats of that stripe), [3] layer_end, [8:4] reserved
- acc2out_pvld  out  1  output word valid
- acc2out_prdy  in  1  downstream ready
- acc2out_data  out  ATOMK_HALF*ACC_WIDTH  completed sums
- acc2out_mask  out  ATOMK_HALF  mask of final-pass beat
- acc2out_last  out  1  last word of layer
- dp2reg_done  out  1  one-cycle pulse
- acc_err  out  1  sticky error
- err_clr  in  1  clears acc_err

## Operation
- Stage 1: beat registered when mac2accu_pvld=1 (pd, mask, mode, data).
- Pointer: stripe_st beat uses entry 0 and loads ptr=1; other beats use ptr, then ptr+1. Beat at ptr>=DEPTH dropped, acc_err set.
- Pass state first_pass: 1 after reset; cleared on a stripe_end beat with channel_end=0; set on a stripe_end beat with channel_end=1.
- Lane value v = mask[i] ? sign-extended data : 0.
- Non-final pass (channel_end=0): entry = first_pass ? v : entry+v.
- Final pass (channel_end=1): sum = (first_pass ? 0 : entry)+v pushed to FIFO with mask, last = layer_end & stripe_end; entry cleared to 0.
- Mode: latched on stripe_st; a mid-stripe beat with different mode sets acc_err and is still processed.
- FIFO full at push with no pop that cycle: word dropped, acc_err set. Full with simultaneous pop: push accepted.
- Pop on acc2out_pvld & acc2out_prdy. dp2reg_done pulses the cycle after popping a word with last=1.
- acc_err: set-priority over err_clr in the same cycle.
- Reset mid-operation: all state cleared; partial sums discarded; no output emitted.

## Timing
- Reset values: acc2out_pvld=0, acc2out_data=0, acc2out_mask=0, acc2out_last=0, dp2reg_done=0, acc_err=0; ptr=0, first_pass=1, entries=0, FIFO empty.
- Beat sampled at edge E; entry/FIFO updated at edge E+1; acc2out_pvld high from E+1 (2-cycle input-to-output latency).
- Back-to-back beats every cycle sustained; same-entry hazard impossible (ptr advances each beat).
- acc2out_data/mask/last stable while acc2out_pvld=1 and acc2out_prdy=0.
- Full throughput: one pop per cycle when prdy=1.

## Configuration
- NVDLA_CACC_SAT_EN defined: accumulate and push sums saturate to ±(2^(ACC_WIDTH-1)) bounds (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)); saturation event also sets acc_err.
- Undefined: two's-complement wrap, acc_err unaffected by arithmetic.

## Test plan
- Single pass: one stripe of 2 beats, pd=stripe_st|channel_end then stripe_end|channel_end|layer_end, lane0=5 then 7, prdy=1 -> two words lane0=5, 7; second last=1; dp2reg_done pulses once.
- Three passes: 4-beat stripe, lane0 values 1,2,3 across passes at entry 0 -> output lane0=6; masked lane with data 100 contributes 0.
- Back-pressure: prdy=0, final stripe 6 beats, OUT_DEPTH=4 -> 4 words held, 2 dropped, acc_err=1; err_clr -> acc_err=0.
- Pointer overflow: 9 beats in one stripe, DEPTH=8 -> 9th beat dropped, acc_err=1, entries 0-7 correct.
- Arithmetic: lane0=-262144 for 2^16 non-final passes then final: NVDLA_CACC_SAT_EN -> -2^33 and acc_err=1; without -> wrapped value.
- Reset asserted mid-stripe after 3 beats -> all outputs 0 immediately; next stripe_st restarts at entry 0, first_pass=1.

Source files
------------

// File: rtl/nv_nvdla_cacc_mac_rcv.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cacc_mac_rcv
//
// Accumulator input of CACC: the receiving end of the mac2accu interface.
// Every MAC result beat is taken without back-pressure. Partial sums are
// accumulated per stripe atom across channel-group passes. On the final
// pass the completed sums are pushed into a small valid/ready output FIFO.
// Pointer overflow, FIFO overflow and mode changes inside a stripe are
// flagged on the sticky acc_err output. The beat is never stalled.
//
// Optional feature: define NVDLA_CACC_SAT_EN to make accumulation saturate
// at the signed ACC_WIDTH bounds. A saturation event also sets acc_err.
// Without the macro the sums wrap in two's complement.
//
// Ports:
//   nvdla_core_clk   in   core clock
//   nvdla_core_rstn  in   asynchronous active-low reset
//   mac2accu_pvld    in   beat valid (no ready)
//   mac2accu_mask    in   per-lane valid
//   mac2accu_mode    in   conv mode, latched on stripe_st
//   mac2accu_data    in   lane i at [i*RESULT_WIDTH +: RESULT_WIDTH]
//   mac2accu_pd      in   [0] stripe_st [1] stripe_end [2] channel_end
//                         [3] layer_end [8:4] reserved
//   acc2out_pvld     out  output word valid
//   acc2out_prdy     in   downstream ready
//   acc2out_data     out  completed sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   acc2out_mask     out  mask of the final-pass beat
//   acc2out_last     out  last word of the layer
//   dp2reg_done      out  one-cycle pulse after the last word is popped
//   acc_err          out  sticky error flag
//   err_clr          in   clears acc_err (a new error in the same cycle wins)
//
// Output handshake: a word transfers on a cycle where acc2out_pvld and
// acc2out_prdy are both 1 at the rising edge; while acc2out_pvld=1 and
// acc2out_prdy=0 the word (data, mask, last) is held stable.
// ---------------------------------------------------------------------------
module nv_nvdla_cacc_mac_rcv #(
   parameter int ATOMK_HALF   = 8,
   parameter int RESULT_WIDTH = 19,
   parameter int ACC_WIDTH    = 34,
   parameter int DEPTH        = 8,
   parameter int OUT_DEPTH    = 4
) (
   input  logic                               nvdla_core_clk,
   input  logic                               nvdla_core_rstn,
   input  logic                               mac2accu_pvld,
   input  logic [ATOMK_HALF-1:0]              mac2accu_mask,
   input  logic                               mac2accu_mode,
   input  logic [ATOMK_HALF*RESULT_WIDTH-1:0] mac2accu_data,
   input  logic [8:0]                         mac2accu_pd,
   output logic                               acc2out_pvld,
   input  logic                               acc2out_prdy,
   output logic [ATOMK_HALF*ACC_WIDTH-1:0]    acc2out_data,
   output logic [ATOMK_HALF-1:0]              acc2out_mask,
   output logic                               acc2out_last,
   output logic                               dp2reg_done,
   output logic                               acc_err,
   input  logic                               err_clr
);

   localparam int LW    = ATOMK_HALF * ACC_WIDTH;
   localparam int IW    = ATOMK_HALF * RESULT_WIDTH;
   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int QW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW    = $clog2(OUT_DEPTH + 1);

   // Stage 1: registered beat
   logic                  r_s1_vld;
   logic [3:0]            r_s1_pd;
   logic [ATOMK_HALF-1:0] r_s1_mask;
   logic                  r_s1_mode;
   logic [IW-1:0]         r_s1_data;

   // Accumulation state
   logic [PTR_W-1:0]      r_ptr;
   logic                  r_first;
   logic                  r_mode;
   logic [LW-1:0]         r_entry [DEPTH];

   // Output FIFO
   logic [LW-1:0]         r_fdata [OUT_DEPTH];
   logic [ATOMK_HALF-1:0] r_fmask [OUT_DEPTH];
   logic                  r_flast [OUT_DEPTH];
   logic [QW-1:0]         r_wr;
   logic [QW-1:0]         r_rd;
   logic [CW-1:0]         r_cnt;
   logic                  r_done;
   logic                  r_err;

   // Reserved pd bits carry nothing for this block.
   logic w_unused_pd;
   assign w_unused_pd = ^mac2accu_pd[8:4];

   logic w_st, w_end, w_chend, w_lend;
   assign w_st    = r_s1_pd[0];
   assign w_end   = r_s1_pd[1];
   assign w_chend = r_s1_pd[2];
   assign w_lend  = r_s1_pd[3];

   // stripe_st always targets entry 0; other beats use the running pointer.
   logic             w_drop;
   logic [IDX_W-1:0] w_idx;
   logic [LW-1:0]    w_entry_rd;
   assign w_drop     = !w_st && (r_ptr >= PTR_W'(DEPTH));
   assign w_idx      = w_st ? '0 : r_ptr[IDX_W-1:0];
   assign w_entry_rd = r_entry[w_idx];

   // Lane adders. One extra bit exposes signed overflow for saturation.
   logic [LW-1:0]           w_sum_vec;
   logic                    w_sat_any;
   logic                    w_unused_ovf;
   logic [ACC_WIDTH-1:0]    w_base;
   logic [ACC_WIDTH-1:0]    w_v;
   logic [ACC_WIDTH:0]      w_wide;
   logic [RESULT_WIDTH-1:0] w_d;

   always_comb begin
      w_sum_vec    = '0;
      w_sat_any    = 1'b0;
      w_unused_ovf = 1'b0;
      w_base       = '0;
      w_v          = '0;
      w_wide       = '0;
      w_d          = '0;
      for (int i = 0; i < ATOMK_HALF; i++) begin
         w_d    = r_s1_data[i*RESULT_WIDTH +: RESULT_WIDTH];
         w_v    = r_s1_mask[i] ? {{(ACC_WIDTH-RESULT_WIDTH){w_d[RESULT_WIDTH-1]}}, w_d} : '0;
         w_base = r_first ? '0 : w_entry_rd[i*ACC_WIDTH +: ACC_WIDTH];
         w_wide = {w_base[ACC_WIDTH-1], w_base} + {w_v[ACC_WIDTH-1], w_v};
         w_unused_ovf = w_unused_ovf | w_wide[ACC_WIDTH];
`ifdef NVDLA_CACC_SAT_EN
         if (w_wide[ACC_WIDTH] != w_wide[ACC_WIDTH-1]) begin
            w_sat_any = 1'b1;
            w_sum_vec[i*ACC_WIDTH +: ACC_WIDTH] = w_wide[ACC_WIDTH] ?
               {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end else begin
            w_sum_vec[i*ACC_WIDTH +: ACC_WIDTH] = w_wide[ACC_WIDTH-1:0];
         end
`else
         w_sum_vec[i*ACC_WIDTH +: ACC_WIDTH] = w_wide[ACC_WIDTH-1:0];
`endif
      end
   end

   // FIFO control. A push into a full FIFO survives only if a pop frees
   // the head in the same cycle (the write then lands in the freed slot).
   logic w_push_req, w_push, w_pop, w_full, w_err_set;
   assign w_full     = (r_cnt == CW'(OUT_DEPTH));
   assign w_pop      = (r_cnt != '0) && acc2out_prdy;
   assign w_push_req = r_s1_vld && !w_drop && w_chend;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_err_set  = r_s1_vld && (w_drop ||
                                    (!w_st && (r_s1_mode != r_mode)) ||
                                    (!w_drop && w_sat_any) ||
                                    (w_push_req && !w_push));

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_s1_vld  <= 1'b0;
         r_s1_pd   <= '0;
         r_s1_mask <= '0;
         r_s1_mode <= 1'b0;
         r_s1_data <= '0;
         r_ptr     <= '0;
         r_first   <= 1'b1;
         r_mode    <= 1'b0;
         r_wr      <= '0;
         r_rd      <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         for (int k = 0; k < DEPTH; k++) r_entry[k] <= '0;
         for (int k = 0; k < OUT_DEPTH; k++) begin
            r_fdata[k] <= '0;
            r_fmask[k] <= '0;
            r_flast[k] <= 1'b0;
         end
      end else begin
         r_s1_vld <= mac2accu_pvld;
         if (mac2accu_pvld) begin
            r_s1_pd   <= mac2accu_pd[3:0];
            r_s1_mask <= mac2accu_mask;
            r_s1_mode <= mac2accu_mode;
            r_s1_data <= mac2accu_data;
         end

         if (r_s1_vld) begin
            // Pointer holds at DEPTH once exhausted so later beats keep dropping.
            if (w_st)         r_ptr <= PTR_W'(1);
            else if (!w_drop) r_ptr <= r_ptr + PTR_W'(1);
            if (w_end)        r_first <= w_chend;
            if (w_st)         r_mode  <= r_s1_mode;
            if (!w_drop)      r_entry[w_idx] <= w_chend ? '0 : w_sum_vec;
         end

         if (w_push) begin
            r_fdata[r_wr] <= w_sum_vec;
            r_fmask[r_wr] <= r_s1_mask;
            r_flast[r_wr] <= w_lend && w_end;
            r_wr          <= (r_wr == QW'(OUT_DEPTH-1)) ? '0 : r_wr + QW'(1);
         end
         if (w_pop) r_rd <= (r_rd == QW'(OUT_DEPTH-1)) ? '0 : r_rd + QW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);

         r_done <= w_pop && r_flast[r_rd];

         if (w_err_set)    r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   // Outputs read zero whenever the FIFO is empty.
   assign acc2out_pvld = (r_cnt != '0);
   assign acc2out_data = acc2out_pvld ? r_fdata[r_rd] : '0;
   assign acc2out_mask = acc2out_pvld ? r_fmask[r_rd] : '0;
   assign acc2out_last = acc2out_pvld && r_flast[r_rd];
   assign dp2reg_done  = r_done;
   assign acc_err      = r_err;

endmodule

// File: tb/tb_nv_nvdla_cacc_mac_rcv.sv
// ---------------------------------------------------------------------------
// Testbench for nv_nvdla_cacc_mac_rcv (default parameters).
// Honours NVDLA_CACC_SAT_EN for the arithmetic boundary expectation.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cacc_mac_rcv;

   localparam int NL = 8;
   localparam int RW = 19;
   localparam int AW = 34;
   localparam int DW = NL * AW;
   localparam int EW = 1 + NL + DW;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            pvld = 1'b0;
   logic [NL-1:0]   mask = '0;
   logic            mode = 1'b0;
   logic [NL*RW-1:0] data = '0;
   logic [8:0]      pd = '0;
   logic            prdy = 1'b0;
   logic            err_clr = 1'b0;
   logic            acc2out_pvld;
   logic [DW-1:0]   acc2out_data;
   logic [NL-1:0]   acc2out_mask;
   logic            acc2out_last;
   logic            dp2reg_done;
   logic            acc_err;

   nv_nvdla_cacc_mac_rcv dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .mac2accu_pvld   (pvld),
      .mac2accu_mask   (mask),
      .mac2accu_mode   (mode),
      .mac2accu_data   (data),
      .mac2accu_pd     (pd),
      .acc2out_pvld    (acc2out_pvld),
      .acc2out_prdy    (prdy),
      .acc2out_data    (acc2out_data),
      .acc2out_mask    (acc2out_mask),
      .acc2out_last    (acc2out_last),
      .dp2reg_done     (dp2reg_done),
      .acc_err         (acc_err),
      .err_clr         (err_clr)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk_exp(input logic last, input logic [NL-1:0] m,
                                            input logic [AW-1:0] e0, input logic [AW-1:0] e1);
      logic [DW-1:0] d;
      d = '0;
      d[AW-1:0]    = e0;
      d[2*AW-1:AW] = e1;
      return {last, m, d};
   endfunction

   // Compare every popped word against the head of the expected queue.
   always @(negedge clk) begin
      if (rstn && acc2out_pvld && prdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", acc2out_data[AW-1:0]);
         end else begin
            check("out_word", {acc2out_last, acc2out_mask, acc2out_data}, exp_q.pop_front());
         end
      end
      if (rstn && dp2reg_done) done_cnt++;
   end

   // ---------------- driver ----------------
   task automatic send(input logic [8:0] p, input logic [NL-1:0] m, input logic md,
                       input int l0, input int l1);
      pvld = 1'b1;
      pd   = p;
      mask = m;
      mode = md;
      data = '0;
      data[RW-1:0]    = RW'(l0);
      data[2*RW-1:RW] = RW'(l1);
      @(posedge clk);
      #1;
      pvld = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, EW'(exp_q.size()), EW'(0));
      exp_q.delete();
      cycles(2);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [8:0]    pd;
      logic [NL-1:0] mask;
      int            l0;
      int            l1;
      logic          push;
      logic          last;
      int            e0;
      int            e1;
   } vec_t;

   function automatic vec_t mk_vec(input logic [8:0] p, input logic [NL-1:0] m, input int l0,
                                   input int l1, input logic push, input logic last,
                                   input int e0, input int e1);
      vec_t v;
      v.pd = p; v.mask = m; v.l0 = l0; v.l1 = l1;
      v.push = push; v.last = last; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   vec_t vt[14];

   initial begin
      logic [AW-1:0] e_arith;
      logic          e_arith_err;

      // Single final pass: two words, second is last of layer.
      vt[0]  = mk_vec(9'h005, 8'hFF,    5,   0, 1'b1, 1'b0,    5, 0);
      vt[1]  = mk_vec(9'h00E, 8'hFF,    7,   0, 1'b1, 1'b1,    7, 0);
      // Three passes over a 4-atom stripe; lane1 masked off with data 100.
      vt[2]  = mk_vec(9'h001, 8'hFD,    1, 100, 1'b0, 1'b0,    0, 0);
      vt[3]  = mk_vec(9'h000, 8'hFD,   11, 100, 1'b0, 1'b0,    0, 0);
      vt[4]  = mk_vec(9'h000, 8'hFD,   21, 100, 1'b0, 1'b0,    0, 0);
      vt[5]  = mk_vec(9'h002, 8'hFD,   31, 100, 1'b0, 1'b0,    0, 0);
      vt[6]  = mk_vec(9'h001, 8'hFD,    2, 100, 1'b0, 1'b0,    0, 0);
      vt[7]  = mk_vec(9'h000, 8'hFD, -500, 100, 1'b0, 1'b0,    0, 0);
      vt[8]  = mk_vec(9'h000, 8'hFD,   22, 100, 1'b0, 1'b0,    0, 0);
      vt[9]  = mk_vec(9'h002, 8'hFD,   32, 100, 1'b0, 1'b0,    0, 0);
      vt[10] = mk_vec(9'h005, 8'hFD,    3, 100, 1'b1, 1'b0,    6, 0);
      vt[11] = mk_vec(9'h004, 8'hFD,   13, 100, 1'b1, 1'b0, -476, 0);
      vt[12] = mk_vec(9'h004, 8'hFD,   23, 100, 1'b1, 1'b0,   66, 0);
      vt[13] = mk_vec(9'h00E, 8'hFD,   33, 100, 1'b1, 1'b1,   96, 0);

      // ---------------- reset ----------------
      rstn = 1'b0;
      cycles(3);
      check("rst_pvld", EW'(acc2out_pvld), EW'(0));
      check("rst_data", EW'(acc2out_data), EW'(0));
      check("rst_mask", EW'(acc2out_mask), EW'(0));
      check("rst_last", EW'(acc2out_last), EW'(0));
      check("rst_done", EW'(dp2reg_done),  EW'(0));
      check("rst_err",  EW'(acc_err),      EW'(0));
      rstn = 1'b1;
      cycles(2);

      // ---------------- table: single pass + three passes ----------------
      prdy = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (vt[i].push)
            exp_q.push_back(mk_exp(vt[i].last, vt[i].mask, AW'(vt[i].e0), AW'(vt[i].e1)));
         send(vt[i].pd, vt[i].mask, 1'b0, vt[i].l0, vt[i].l1);
      end
      drain("table_drain");
      check("table_done_cnt", EW'(done_cnt), EW'(2));
      check("table_no_err",   EW'(acc_err),  EW'(0));

      // ---------------- back-pressure: 6 final beats into 4-deep FIFO ----------------
      prdy = 1'b0;
      send(9'h005, 8'h01, 1'b0, 1, 0);
      for (int b = 2; b <= 5; b++) send(9'h004, 8'h01, 1'b0, b, 0);
      send(9'h006, 8'h01, 1'b0, 6, 0);
      cycles(3);
      check("bp_pvld",     EW'(acc2out_pvld),        EW'(1));
      check("bp_head",     EW'(acc2out_data[AW-1:0]), EW'(1));
      check("bp_err",      EW'(acc_err),             EW'(1));
      cycles(3);
      check("bp_hold",     EW'(acc2out_data[AW-1:0]), EW'(1));
      for (int b = 1; b <= 4; b++) exp_q.push_back(mk_exp(1'b0, 8'h01, AW'(b), AW'(0)));
      prdy = 1'b1;
      drain("bp_drain");
      check("bp_empty",    EW'(acc2out_pvld), EW'(0));
      clear_err();
      check("bp_err_clr",  EW'(acc_err), EW'(0));

      // ---------------- pointer overflow ----------------
      send(9'h001, 8'h01, 1'b0, 1, 0);
      for (int b = 1; b < 8; b++) send(9'h000, 8'h01, 1'b0, b + 1, 0);
      send(9'h002, 8'h01, 1'b0, 9, 0);
      cycles(2);
      check("ovf_err", EW'(acc_err), EW'(1));
      clear_err();
      for (int b = 0; b < 8; b++) exp_q.push_back(mk_exp(1'b0, 8'h01, AW'(101 + b), AW'(0)));
      send(9'h005, 8'h01, 1'b0, 100, 0);
      for (int b = 1; b < 7; b++) send(9'h004, 8'h01, 1'b0, 100, 0);
      send(9'h006, 8'h01, 1'b0, 100, 0);
      drain("ovf_drain");
      check("ovf_err_clean", EW'(acc_err), EW'(0));

      // ---------------- mode change mid-stripe ----------------
      exp_q.push_back(mk_exp(1'b0, 8'h01, AW'(4), AW'(0)));
      exp_q.push_back(mk_exp(1'b0, 8'h01, AW'(8), AW'(0)));
      send(9'h005, 8'h01, 1'b0, 4, 0);
      send(9'h006, 8'h01, 1'b1, 8, 0);
      drain("mode_drain");
      check("mode_err", EW'(acc_err), EW'(1));
      clear_err();

      // ---------------- arithmetic boundary ----------------
      for (int p = 0; p < 65536; p++) send(9'h003, 8'h01, 1'b0, -262144, 0);
`ifdef NVDLA_CACC_SAT_EN
      e_arith     = {1'b1, {(AW-1){1'b0}}};
      e_arith_err = 1'b1;
`else
      e_arith     = AW'(-262144);
      e_arith_err = 1'b0;
`endif
      exp_q.push_back(mk_exp(1'b0, 8'h01, e_arith, AW'(0)));
      send(9'h007, 8'h01, 1'b0, -262144, 0);
      drain("arith_drain");
      check("arith_err", EW'(acc_err), EW'(e_arith_err));
      clear_err();

      // ---------------- reset mid-stripe ----------------
      prdy = 1'b0;
      send(9'h007, 8'h01, 1'b0, 77, 0);
      send(9'h003, 8'h01, 1'b0, 50, 0);
      send(9'h001, 8'h01, 1'b1, 1, 0);
      send(9'h000, 8'h01, 1'b0, 2, 0);
      send(9'h000, 8'h01, 1'b0, 3, 0);
      cycles(2);
      check("pre_rst_pvld", EW'(acc2out_pvld), EW'(1));
      check("pre_rst_err",  EW'(acc_err),      EW'(1));
      rstn = 1'b0;
      #1;
      check("mid_rst_pvld", EW'(acc2out_pvld), EW'(0));
      check("mid_rst_data", EW'(acc2out_data), EW'(0));
      check("mid_rst_mask", EW'(acc2out_mask), EW'(0));
      check("mid_rst_last", EW'(acc2out_last), EW'(0));
      check("mid_rst_done", EW'(dp2reg_done),  EW'(0));
      check("mid_rst_err",  EW'(acc_err),      EW'(0));
      cycles(2);
      rstn = 1'b1;
      prdy = 1'b1;
      cycles(1);
      exp_q.push_back(mk_exp(1'b1, 8'h01, AW'(9), AW'(0)));
      send(9'h00F, 8'h01, 1'b0, 9, 0);
      drain("rst_drain");
      check("total_done_cnt", EW'(done_cnt), EW'(3));
      check("final_err",      EW'(acc_err),  EW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
